proj_topk_sorter: RTL and testbench

Streaming bottom-K selector for the MinHash datapath, successor to `proj_sorter`. It sits between the hasher and the extender and accepts one (signature, index) pair per cycle under a valid/ready handshake. It keeps the K smallest signatures of the current frame in an ascending insertion-sorted register array, and on frame end publishes their indices plus a valid-entry count through a held output handshake. New relative to `proj_sorter`: framing (`in_first`/`in_last`), a per-entry valid flag with fewer-than-K handling, optional duplicate suppression, stable tie order, and output backpressure.

---
 rtl/proj_topk_sorter.sv | 150 +++++++++++++++
 tb/tb_proj_topk_sorter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_topk_sorter.sv
// rtl/proj_topk_sorter.sv - streaming bottom-K selector with framing and held output
// Keeps the K smallest signatures of a frame in a sorted register array; publishes on in_last.
module proj_topk_sorter #(
  parameter int INDICES_COUNT = 8,
  parameter int SIGNATURE_LEN = 32,
  parameter int INDICE_LEN    = 8,
  parameter int DEDUP         = 0
) (
  input  logic                                  in_clk,
  input  logic                                  in_rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SIGNATURE_LEN-1:0]              in_signature,
  input  logic [INDICE_LEN-1:0]                 in_index,
  input  logic                                  in_first,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [INDICES_COUNT*INDICE_LEN-1:0]   out_smallest_idx,
  output logic [INDICES_COUNT*SIGNATURE_LEN-1:0] out_smallest_sig,
  output logic [$clog2(INDICES_COUNT+1)-1:0]    out_count
);

  localparam int K  = INDICES_COUNT;
  localparam int SW = SIGNATURE_LEN;
  localparam int IW = INDICE_LEN;
  localparam int CW = $clog2(INDICES_COUNT+1);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [K-1:0]  vld_q, vld_d;
  logic [SW-1:0] sig_q [K];
  logic [SW-1:0] sig_d [K];
  logic [IW-1:0] idx_q [K];
  logic [IW-1:0] idx_d [K];

  logic [K*IW-1:0] out_idx_q, out_idx_d;
  logic [K*SW-1:0] out_sig_q, out_sig_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;

  logic [K-1:0]  base_v, le, eq, prev_le;
  logic          dup, accept, publish;
  logic [K-1:0]  ins_v;
  logic [SW-1:0] ins_s [K];
  logic [IW-1:0] ins_i [K];
  logic [CW-1:0] ins_cnt;

  assign in_ready  = (state_q == ST_COLLECT) || out_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign publish   = accept && in_last;

  assign out_smallest_idx = out_idx_q;
  assign out_smallest_sig = out_sig_q;
  assign out_count        = out_cnt_q;

  // le is a thermometer prefix because valid slots are contiguous and ascending,
  // so the insert position is the first slot whose le is clear.
  always_comb begin
    base_v = in_first ? '0 : vld_q;
    for (int i = 0; i < K; i++) begin
      le[i] = base_v[i] && (sig_q[i] <= in_signature);
      eq[i] = base_v[i] && (sig_q[i] == in_signature);
    end
    dup     = (DEDUP != 0) && (|eq);
    prev_le = {le[K-2:0], 1'b1};
    for (int i = 0; i < K; i++) begin
      ins_v[i] = base_v[i];
      ins_s[i] = sig_q[i];
      ins_i[i] = idx_q[i];
      if (!dup && !le[i] && prev_le[i]) begin
        ins_v[i] = 1'b1;
        ins_s[i] = in_signature;
        ins_i[i] = in_index;
      end
    end
    for (int i = 1; i < K; i++) begin
      if (!dup && !le[i] && !prev_le[i]) begin
        ins_v[i] = base_v[i-1];
        ins_s[i] = sig_q[i-1];
        ins_i[i] = idx_q[i-1];
      end
    end
    ins_cnt = '0;
    for (int i = 0; i < K; i++) begin
      ins_cnt = ins_cnt + {{(CW-1){1'b0}}, ins_v[i]};
    end
  end

  always_comb begin
    vld_d     = vld_q;
    out_idx_d = out_idx_q;
    out_sig_d = out_sig_q;
    out_cnt_d = out_cnt_q;
    for (int i = 0; i < K; i++) begin
      sig_d[i] = sig_q[i];
      idx_d[i] = idx_q[i];
    end
    if (accept) begin
      vld_d = in_last ? '0 : ins_v;
      for (int i = 0; i < K; i++) begin
        sig_d[i] = ins_s[i];
        idx_d[i] = ins_i[i];
      end
    end
    if (publish) begin
      out_cnt_d = ins_cnt;
      for (int i = 0; i < K; i++) begin
        out_idx_d[i*IW +: IW] = ins_v[i] ? ins_i[i] : '0;
        out_sig_d[i*SW +: SW] = ins_v[i] ? ins_s[i] : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (publish) begin
      state_d = ST_HOLD;
    end else if (state_q == ST_HOLD && out_ready) begin
      state_d = ST_COLLECT;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= ST_COLLECT;
      vld_q     <= '0;
      out_idx_q <= '0;
      out_sig_q <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < K; i++) begin
        sig_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      out_idx_q <= out_idx_d;
      out_sig_q <= out_sig_d;
      out_cnt_q <= out_cnt_d;
      for (int i = 0; i < K; i++) begin
        sig_q[i] <= sig_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

endmodule

// File: tb/tb_proj_topk_sorter.sv
// tb/tb_proj_topk_sorter.sv - scoreboard bench for proj_topk_sorter, DEDUP=0 and DEDUP=1 side by side
module tb_proj_topk_sorter;

  localparam int K  = 8;
  localparam int SW = 32;
  localparam int IW = 8;

  typedef struct packed {
    logic [3:0]      cnt;
    logic [K*IW-1:0] idx;
    logic [K*SW-1:0] sig;
  } res_t;

  typedef struct packed {
    logic [SW-1:0] s;
    logic [IW-1:0] i;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [SW-1:0] in_signature = '0;
  logic [IW-1:0] in_index = '0;
  logic in_ready0, in_ready1, ov0, ov1;
  logic [K*IW-1:0] o0_idx, o1_idx;
  logic [K*SW-1:0] o0_sig, o1_sig;
  logic [3:0] o0_cnt, o1_cnt;

  int comps = 0;
  int fails = 0;
  bit rand_rdy = 0;
  bit push_model = 0;
  beat_t frame[$];
  res_t q0[$];
  res_t q1[$];
  res_t prev[2];
  bit stall_prev[2];

  always #5 clk = ~clk;

  proj_topk_sorter #(.INDICES_COUNT(K), .SIGNATURE_LEN(SW), .INDICE_LEN(IW), .DEDUP(0)) dut0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_signature(in_signature), .in_index(in_index), .in_first(in_first), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_smallest_idx(o0_idx),
    .out_smallest_sig(o0_sig), .out_count(o0_cnt));

  proj_topk_sorter #(.INDICES_COUNT(K), .SIGNATURE_LEN(SW), .INDICE_LEN(IW), .DEDUP(1)) dut1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_signature(in_signature), .in_index(in_index), .in_first(in_first), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_smallest_idx(o1_idx),
    .out_smallest_sig(o1_sig), .out_count(o1_cnt));

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    comps++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference: pick the K smallest by repeated minimum search, earliest arrival wins ties.
  function automatic res_t bottomk(input bit dd);
    beat_t src[$];
    bit    used[$];
    bit    seen;
    int    best;
    res_t  r;
    r = '0;
    foreach (frame[n]) begin
      seen = 0;
      foreach (src[m]) if (src[m].s == frame[n].s) seen = 1;
      if (!(dd && seen)) src.push_back(frame[n]);
    end
    foreach (src[n]) used.push_back(1'b0);
    for (int k = 0; k < K; k++) begin
      best = -1;
      foreach (src[j]) if (!used[j] && (best < 0 || src[j].s < src[best].s)) best = j;
      if (best >= 0) begin
        used[best] = 1'b1;
        r.idx[k*IW +: IW] = src[best].i;
        r.sig[k*SW +: SW] = src[best].s;
        r.cnt = r.cnt + 4'd1;
      end
    end
    return r;
  endfunction

  task automatic model_accept(input logic [SW-1:0] s, input logic [IW-1:0] ix, input bit f, input bit l);
    beat_t b;
    b.s = s;
    b.i = ix;
    if (f) frame.delete();
    frame.push_back(b);
    if (l) begin
      if (push_model) begin
        q0.push_back(bottomk(1'b0));
        q1.push_back(bottomk(1'b1));
      end
      frame.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_signature = $urandom;
    in_first = 1'($urandom);
    in_last = 1'($urandom);
    tick();
    in_first = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_beat(input logic [SW-1:0] s, input logic [IW-1:0] ix, input bit f, input bit l,
                           output int waits);
    bit acc;
    acc = 0;
    waits = 0;
    in_valid = 1'b1; in_signature = s; in_index = ix; in_first = f; in_last = l;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      if (in_ready0) acc = 1;
      else begin
        waits++;
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    chk("accept_timeout", 256'(acc), 256'd1);
    if (acc) begin
      @(posedge clk);
      model_accept(s, ix, f, l);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic mon(input int w, input logic ov, input logic rdy, input res_t cur);
    res_t exp;
    bit   bad;
    if (stall_prev[w] && ov) chk($sformatf("stable%0d", w), 256'(cur), 256'(prev[w]));
    if (ov) begin
      bad = 0;
      for (int j = 0; j + 1 < int'(cur.cnt); j++)
        if (cur.sig[j*SW +: SW] > cur.sig[(j+1)*SW +: SW]) bad = 1;
      chk($sformatf("ascending%0d", w), 256'(bad), 256'd0);
      chk($sformatf("in_ready%0d", w), 256'(w == 0 ? in_ready0 : in_ready1), 256'(out_ready));
    end else begin
      chk($sformatf("in_ready_idle%0d", w), 256'(w == 0 ? in_ready0 : in_ready1), 256'd1);
    end
    if (ov && rdy) begin
      if ((w == 0 ? q0.size() : q1.size()) == 0) begin
        chk($sformatf("unexpected_output%0d", w), 256'd1, 256'd0);
      end else begin
        exp = (w == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("count%0d", w), 256'(cur.cnt), 256'(exp.cnt));
        chk($sformatf("idx%0d", w), 256'(cur.idx), 256'(exp.idx));
        chk($sformatf("sig%0d", w), 256'(cur.sig), 256'(exp.sig));
      end
    end
    stall_prev[w] = ov && !rdy;
    prev[w] = cur;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev[0] = 0;
      stall_prev[1] = 0;
    end else begin
      mon(0, ov0, out_ready, {o0_cnt, o0_idx, o0_sig});
      mon(1, ov1, out_ready, {o1_cnt, o1_idx, o1_sig});
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, 256'({ov0, ov1}), 256'd0);
    chk({nm, "_ready"}, 256'({in_ready0, in_ready1}), 256'b11);
    chk({nm, "_out0"}, 256'({o0_cnt, o0_idx, o0_sig}), 256'd0);
    chk({nm, "_out1"}, 256'({o1_cnt, o1_idx, o1_sig}), 256'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    frame.delete();
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    res_t e;
    int w, n;
    bit f;
    #2;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Descending frame 10..1: expect indices 1..8 ascending.
    e = '0;
    e.cnt = 4'd8;
    for (int k = 0; k < K; k++) begin
      e.idx[k*IW +: IW] = 8'(k + 1);
      e.sig[k*SW +: SW] = 32'(k + 1) * 32'h1010_1010;
    end
    q0.push_back(e);
    q1.push_back(e);
    for (int i = 10; i >= 1; i--) send_beat(32'(i) * 32'h1010_1010, 8'(i), i == 10, i == 1, w);
    chk("out_valid_after_last", 256'({ov0, ov1}), 256'b11);

    // Short frame.
    e = '0;
    e.cnt = 4'd3;
    e.idx[23:0] = 24'h03_02_01;
    e.sig[95:0] = {32'h30, 32'h20, 32'h10};
    q0.push_back(e);
    q1.push_back(e);
    send_beat(32'h30, 8'd3, 1, 0, w);
    send_beat(32'h10, 8'd1, 0, 0, w);
    send_beat(32'h20, 8'd2, 0, 1, w);

    // Ties, then hold the result under backpressure.
    e = '0;
    e.cnt = 4'd2;
    e.idx[15:0] = 16'h09_07;
    e.sig[63:0] = {32'h50, 32'h50};
    q0.push_back(e);
    e = '0;
    e.cnt = 4'd1;
    e.idx[7:0] = 8'h07;
    e.sig[31:0] = 32'h50;
    q1.push_back(e);
    send_beat(32'h50, 8'd7, 1, 0, w);
    out_ready = 1'b0;
    send_beat(32'h50, 8'd9, 0, 1, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 256'({in_ready0, in_ready1}), 256'd0);
      chk("bp_out_valid", 256'({ov0, ov1}), 256'b11);
      @(posedge clk);
      #1;
    end
    e = '0;
    e.cnt = 4'd2;
    e.idx[15:0] = 16'h0A_0B;
    e.sig[63:0] = {32'h5, 32'h3};
    q0.push_back(e);
    q1.push_back(e);
    out_ready = 1'b1;
    send_beat(32'h5, 8'h0A, 1, 0, w);
    chk("bp_same_cycle_accept", 256'(w), 256'd0);
    send_beat(32'h3, 8'h0B, 0, 1, w);
    repeat (2) tick();

    // Reset mid-frame, then a frame without in_first must hold no stale entries.
    push_model = 1;
    send_beat(32'h1, 8'h11, 1, 0, w);
    send_beat(32'h2, 8'h12, 0, 0, w);
    #2;
    do_reset();
    send_beat(32'h40, 8'h21, 0, 0, w);
    send_beat(32'h20, 8'h22, 0, 1, w);
    repeat (2) tick();

    // Reset while holding a stalled result.
    out_ready = 1'b0;
    send_beat(32'h7, 8'h31, 1, 1, w);
    tick();
    #2;
    do_reset();
    out_ready = 1'b1;
    send_beat(32'h9, 8'h41, 0, 1, w);
    repeat (2) tick();

    // Random frames with ties, discarded partials, idle beats and random backpressure.
    rand_rdy = 1;
    for (int fr = 0; fr < 200; fr++) begin
      f = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        for (int b = 0; b < int'($urandom_range(1, 5)); b++)
          send_beat($urandom_range(0, 15), 8'($urandom), b == 0, 0, w);
        f = 1;
      end
      n = $urandom_range(1, 40);
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 4) == 0) idle();
        send_beat($urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : 32'($urandom),
                  8'($urandom), (b == 0) && f, b == n - 1, w);
      end
    end

    rand_rdy = 0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("drain0", 256'(q0.size()), 256'd0);
    chk("drain1", 256'(q1.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
